modinv_invert_loop_ctrl: RTL and testbench

Sequencer for the binary (almost-) inverse loop of the modular invertor. Per iteration it launches the precompute helper (which produces doubled/halved/difference buffers and the u/v comparison flags), latches the flags, and either terminates or launches the invert-update helper with frozen flags. It counts completed iterations in `k` for the correction stage that follows. It sits between the top-level invertor FSM and the precompute/update helpers.

---
 rtl/modinv_invert_loop_ctrl.sv | 133 +++++++++++++
 tb/tb_modinv_invert_loop_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_invert_loop_ctrl.sv
// Iteration sequencer for the binary almost-inverse loop: alternates precompute and
// update helper runs, freezes the comparison flags between them and counts iterations.
module modinv_invert_loop_ctrl #(
  parameter int OPERAND_NUM_BITS = 256,
  parameter int MAX_ITERATIONS   = 2 * OPERAND_NUM_BITS,
  parameter int ITER_CNT_BITS    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  output logic                     rdy,
  output logic                     done_ok,
  output logic                     err_overrun,
  output logic [ITER_CNT_BITS-1:0] k,
  output logic                     prep_ena,
  input  logic                     prep_rdy,
  input  logic                     u_gt_v_in,
  input  logic                     v_eq_1_in,
  input  logic                     u_is_even_in,
  input  logic                     v_is_even_in,
  output logic                     upd_ena,
  input  logic                     upd_rdy,
  output logic                     u_gt_v,
  output logic                     v_eq_1,
  output logic                     u_is_even,
  output logic                     v_is_even
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREP_TRIG = 3'd1,
    ST_PREP_GAP  = 3'd2,
    ST_PREP_WAIT = 3'd3,
    ST_DECIDE    = 3'd4,
    ST_UPD_TRIG  = 3'd5,
    ST_UPD_GAP   = 3'd6,
    ST_UPD_WAIT  = 3'd7
  } state_t;

  localparam logic [ITER_CNT_BITS-1:0] MAX_K  = ITER_CNT_BITS'(MAX_ITERATIONS);
  localparam logic [ITER_CNT_BITS-1:0] K_ZERO = {ITER_CNT_BITS{1'b0}};
  localparam logic [ITER_CNT_BITS-1:0] K_ONE  = ITER_CNT_BITS'(1);

  state_t                   state_q, state_d;
  logic [ITER_CNT_BITS-1:0] k_q, k_d;
  logic                     done_ok_q, done_ok_d;
  logic                     err_q, err_d;
  // Flag order: {u_gt_v, v_eq_1, u_is_even, v_is_even}
  logic [3:0]               flags_q, flags_d;

  // Next-state and datapath decode; flags only move on the precompute capture edge
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    done_ok_d = done_ok_q;
    err_d     = err_q;
    flags_d   = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          k_d       = K_ZERO;
          done_ok_d = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_PREP_TRIG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP_TRIG: state_d = ST_PREP_GAP;
      ST_PREP_GAP:  state_d = ST_PREP_WAIT;
      ST_PREP_WAIT: begin
        if (prep_rdy) begin
          flags_d = {u_gt_v_in, v_eq_1_in, u_is_even_in, v_is_even_in};
          state_d = ST_DECIDE;
        end else begin
          state_d = ST_PREP_WAIT;
        end
      end
      ST_DECIDE: begin
        if (flags_q[2]) begin
          done_ok_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (k_q == MAX_K) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_UPD_TRIG;
        end
      end
      ST_UPD_TRIG: state_d = ST_UPD_GAP;
      ST_UPD_GAP:  state_d = ST_UPD_WAIT;
      ST_UPD_WAIT: begin
        // DECIDE already refused to launch an update at MAX_K, so this cannot wrap
        if (upd_rdy) begin
          k_d     = k_q + K_ONE;
          state_d = ST_PREP_TRIG;
        end else begin
          state_d = ST_UPD_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= K_ZERO;
      done_ok_q <= 1'b0;
      err_q     <= 1'b0;
      flags_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      done_ok_q <= done_ok_d;
      err_q     <= err_d;
      flags_q   <= flags_d;
    end
  end

  assign rdy         = (state_q == ST_IDLE);
  assign prep_ena    = (state_q == ST_PREP_TRIG);
  assign upd_ena     = (state_q == ST_UPD_TRIG);
  assign done_ok     = done_ok_q;
  assign err_overrun = err_q;
  assign k           = k_q;
  assign u_gt_v      = flags_q[3];
  assign v_eq_1      = flags_q[2];
  assign u_is_even   = flags_q[1];
  assign v_is_even   = flags_q[0];

endmodule

// File: tb/tb_modinv_invert_loop_ctrl.sv
// Directed bench for modinv_invert_loop_ctrl with behavioural precompute/update helpers
// (P=U=12) and MAX_ITERATIONS=4 so the overrun path is reachable.
module tb_modinv_invert_loop_ctrl;

  localparam int P  = 12;
  localparam int U  = 12;
  localparam int KW = 10;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          rdy;
  logic          done_ok;
  logic          err_overrun;
  logic [KW-1:0] k;
  logic          prep_ena;
  logic          prep_rdy;
  logic          u_gt_v_in, v_eq_1_in, u_is_even_in, v_is_even_in;
  logic          upd_ena;
  logic          upd_rdy;
  logic          u_gt_v, v_eq_1, u_is_even, v_is_even;

  int checks   = 0;
  int failures = 0;

  // Written only by the helper model process
  int cyc    = 0;
  int n_prep = 0;
  int n_upd  = 0;
  int ovl    = 0;
  int upd_cyc [64];

  modinv_invert_loop_ctrl #(
    .OPERAND_NUM_BITS(256),
    .MAX_ITERATIONS  (4),
    .ITER_CNT_BITS   (KW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .rdy         (rdy),
    .done_ok     (done_ok),
    .err_overrun (err_overrun),
    .k           (k),
    .prep_ena    (prep_ena),
    .prep_rdy    (prep_rdy),
    .u_gt_v_in   (u_gt_v_in),
    .v_eq_1_in   (v_eq_1_in),
    .u_is_even_in(u_is_even_in),
    .v_is_even_in(v_is_even_in),
    .upd_ena     (upd_ena),
    .upd_rdy     (upd_rdy),
    .u_gt_v      (u_gt_v),
    .v_eq_1      (v_eq_1),
    .u_is_even   (u_is_even),
    .v_is_even   (v_is_even)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Helper model: busy for P/U cycles starting the cycle after the enable pulse
  initial begin
    int  pc, uc;
    logic pe, ue, pe_prev, ue_prev;
    pc = 0; uc = 0; pe_prev = 1'b0; ue_prev = 1'b0;
    prep_rdy = 1'b1;
    upd_rdy  = 1'b1;
    forever begin
      @(negedge clk);
      pe = prep_ena;
      ue = upd_ena;
      if (pe) n_prep++;
      if (ue) begin
        upd_cyc[n_upd % 64] = cyc;
        n_upd++;
      end
      if ((pe && ue) || (pe && pe_prev) || (ue && ue_prev)) ovl++;
      pe_prev = pe;
      ue_prev = ue;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        pc = 0; uc = 0;
      end else begin
        if (pe) pc = P; else if (pc > 0) pc--;
        if (ue) uc = U; else if (uc > 0) uc--;
      end
      prep_rdy = (pc == 0);
      upd_rdy  = (uc == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int fin, base_p, base_u, start_cyc;
  bit busy_ena, chk_snap;
  logic [3:0] snap;

  // Start a run and follow it until rdy returns; n is the cycle index of that rdy
  task automatic run(input int fin_i, input bit busy_i, output int n);
    fin      = fin_i;
    busy_ena = busy_i;
    chk_snap = 1'b0;
    base_p   = n_prep;
    base_u   = n_upd;
    v_eq_1_in = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #2;
    ena = 1'b0;
    start_cyc = cyc;
    n = 1;
    chk("start_rdy_low", rdy, 1'b0);
    chk("start_prep_ena", prep_ena, 1'b1);
    while (!rdy && n < 400) begin
      v_eq_1_in = (fin != 0) && ((n_prep - base_p) == fin);
      if (busy_ena) ena = (n == 5) || (n == 20);
      if (prep_ena && chk_snap)
        chk("flags_frozen", {u_gt_v, v_eq_1, u_is_even, v_is_even}, snap);
      if (upd_ena) begin
        snap = {u_gt_v_in, 1'b0, u_is_even_in, v_is_even_in};
        chk("flags_latched", {u_gt_v, v_eq_1, u_is_even, v_is_even}, snap);
        {u_gt_v_in, u_is_even_in, v_is_even_in} = {u_gt_v_in, u_is_even_in, v_is_even_in} ^ 3'b110;
        chk_snap = 1'b1;
      end
      @(posedge clk);
      #2;
      n++;
    end
    ena = 1'b0;
    chk("run_timeout", rdy, 1'b1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ena = 1'b1;
    u_gt_v_in = 1'b1; v_eq_1_in = 1'b0; u_is_even_in = 1'b0; v_is_even_in = 1'b1;

    // Reset with ena held high
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_k", k, 0);
    chk("rst_done_ok", done_ok, 1'b0);
    chk("rst_err", err_overrun, 1'b0);
    chk("rst_prep_ena", prep_ena, 1'b0);
    chk("rst_upd_ena", upd_ena, 1'b0);
    chk("rst_flags", {u_gt_v, v_eq_1, u_is_even, v_is_even}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b0;
    @(posedge clk);
    #2;
    chk("idle_no_prep", prep_ena, 1'b0);
    chk("idle_rdy", rdy, 1'b1);

    // Immediate finish: first prep reports v==1
    run(1, 1'b0, n);
    chk("imm_cycle", n, 16);
    chk("imm_done_ok", done_ok, 1'b1);
    chk("imm_err", err_overrun, 1'b0);
    chk("imm_k", k, 0);
    chk("imm_upds", n_upd - base_u, 0);
    chk("imm_preps", n_prep - base_p, 1);

    // Three iterations, v==1 on the fourth prep, busy ena pulses ignored
    run(4, 1'b1, n);
    chk("it3_cycle", n, 103);
    chk("it3_k", k, 3);
    chk("it3_done_ok", done_ok, 1'b1);
    chk("it3_err", err_overrun, 1'b0);
    chk("it3_upds", n_upd - base_u, 3);
    chk("it3_preps", n_prep - base_p, 4);
    chk("it3_first_upd", upd_cyc[base_u % 64] - start_cyc, 15);
    chk("it3_gap1", upd_cyc[(base_u + 1) % 64] - upd_cyc[base_u % 64], 29);
    chk("it3_gap2", upd_cyc[(base_u + 2) % 64] - upd_cyc[(base_u + 1) % 64], 29);

    // Overrun at MAX_ITERATIONS=4
    run(0, 1'b0, n);
    chk("ovr_cycle", n, 132);
    chk("ovr_k", k, 4);
    chk("ovr_err", err_overrun, 1'b1);
    chk("ovr_done_ok", done_ok, 1'b0);
    chk("ovr_upds", n_upd - base_u, 4);
    chk("ovr_preps", n_prep - base_p, 5);

    // Mid-run reset during the third update (k==2)
    base_u = n_upd;
    v_eq_1_in = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #2;
    ena = 1'b0;
    n = 0;
    while ((n_upd - base_u) < 3 && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("mid_reach_upd3", n_upd - base_u, 3);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_k_before", k, 2);
    chk("mid_in_upd_wait", {rdy, upd_rdy}, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_rst_rdy", rdy, 1'b1);
    chk("mid_rst_k", k, 0);
    chk("mid_rst_err", err_overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b0, n);
    chk("post_rst_cycle", n, 16);
    chk("post_rst_done_ok", done_ok, 1'b1);

    chk("enable_overlap", ovl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
